// File: rtl/spi_mem_port_arbiter.sv
// spi_mem_port_arbiter: shares RAM port B between SPI rx (m0) and tx (m1).
// Round-robin grant, bounded lock ownership, 1-cycle read return routing.
module spi_mem_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m0_write,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic                m0_lock,
  output logic                m0_ack,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic                m1_req,
  input  logic                m1_write,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic                m1_lock,
  output logic                m1_ack,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    FREE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic [CNT_W-1:0] lock_cnt;
  logic             cnt_done;
  logic             gnt0;
  logic             gnt1;
  logic [1:0]       rdv_q;

  // the cycle that would bring the hold count to LOCK_MAX is the last one
  assign cnt_done = (lock_cnt >= CNT_W'(LOCK_MAX - 1));

  // owner state register
  always_ff @(posedge clk) begin
    if (reset) state <= FREE;
    else       state <= state_nxt;
  end

  // owner next-state: take ownership on a locked grant, drop on unlock or timeout
  always_comb begin
    state_nxt = state;
    unique case (state)
      FREE: begin
        if (gnt0 && m0_lock)      state_nxt = OWN0;
        else if (gnt1 && m1_lock) state_nxt = OWN1;
      end
      OWN0: begin
        if (cnt_done || (gnt0 && !m0_lock) || (!m0_req && !m0_lock))
          state_nxt = FREE;
      end
      OWN1: begin
        if (cnt_done || (gnt1 && !m1_lock) || (!m1_req && !m1_lock))
          state_nxt = FREE;
      end
      default: state_nxt = FREE;
    endcase
  end

  // grant decode: owner exclusive, otherwise round-robin on conflict
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      unique case (state)
        FREE: begin
          if (m0_req && m1_req) begin
            gnt0 = last_grant;
            gnt1 = !last_grant;
          end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
          end
        end
        OWN0:    gnt0 = m0_req;
        OWN1:    gnt1 = m1_req;
        default: ;
      endcase
    end
  end

  // RAM port mux: mirror the granted master, idle to all zeros
  always_comb begin
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    unique case (1'b1)
      gnt0: begin
        mem_chipselect = 1'b1;
        mem_write      = m0_write;
        mem_address    = m0_address;
        mem_byteenable = m0_byteenable;
        mem_writedata  = m0_writedata;
      end
      gnt1: begin
        mem_chipselect = 1'b1;
        mem_write      = m1_write;
        mem_address    = m1_address;
        mem_byteenable = m1_byteenable;
        mem_writedata  = m1_writedata;
      end
      default: ;
    endcase
  end

  // hold counter: 1 on lock entry, counts each owned cycle, clears when free
  always_ff @(posedge clk) begin
    if (reset || state_nxt == FREE)
      lock_cnt <= '0;
    else if (state == FREE)
      lock_cnt <= CNT_W'(1);
    else if (lock_cnt != CNT_W'(LOCK_MAX))
      lock_cnt <= lock_cnt + CNT_W'(1);
  end

  // round-robin memory of the most recent winner
  always_ff @(posedge clk) begin
    if (reset)     last_grant <= 1'b1;
    else if (gnt0) last_grant <= 1'b0;
    else if (gnt1) last_grant <= 1'b1;
  end

  // read tag: one-hot issuing master of a granted read
  always_ff @(posedge clk) begin
    if (reset) rdv_q <= 2'b00;
    else       rdv_q <= {gnt1 && !m1_write, gnt0 && !m0_write};
  end

  assign m0_ack = gnt0;
  assign m1_ack = gnt1;

  // a reset landing on a read's return cycle suppresses that return
  assign m0_readdatavalid = rdv_q[0] && !reset;
  assign m1_readdatavalid = rdv_q[1] && !reset;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_spi_mem_port_arbiter.sv
// tb_spi_mem_port_arbiter: directed + random checks of the port-B arbiter
// against a rule-level ownership/round-robin model and a shadow memory.
module tb_spi_mem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int LM = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          rq [2];
  logic          wr [2];
  logic          lk [2];
  logic [AW-1:0] ad [2];
  logic [BW-1:0] be [2];
  logic [DW-1:0] wd [2];

  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic          mem_chipselect, mem_write;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;

  spi_mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_req(rq[0]), .m0_write(wr[0]), .m0_address(ad[0]),
    .m0_byteenable(be[0]), .m0_writedata(wd[0]), .m0_lock(lk[0]),
    .m0_ack(m0_ack), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_req(rq[1]), .m1_write(wr[1]), .m1_address(ad[1]),
    .m1_byteenable(be[1]), .m1_writedata(wd[1]), .m1_lock(lk[1]),
    .m1_ack(m1_ack), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  // the RAM behind port B
  logic [DW-1:0] ram [1024];
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b])
            ram[mem_address][8*b+:8] <= mem_writedata[8*b+:8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: owner (-1 = nobody), cycles held, last winner,
  // preferred master after a forced release, pending read return
  logic [DW-1:0] ref_mem [1024];
  int            own = -1;
  int            held = 0;
  int            last = 1;
  int            fpref = -1;
  int            pend = -1;
  logic [DW-1:0] pend_d;
  int            g = -1;

  function automatic int mdl_grant();
    if (reset) return -1;
    if (own >= 0) return rq[own[0]] ? own : -1;
    if (rq[0] && rq[1]) return (fpref >= 0) ? fpref : 1 - last;
    if (rq[0]) return 0;
    if (rq[1]) return 1;
    return -1;
  endfunction

  task automatic settle();
    logic          ew, e0, e1;
    logic [AW-1:0] ea;
    logic [BW-1:0] eb;
    logic [DW-1:0] ed;
    #1;
    g  = mdl_grant();
    ew = 1'b0; ea = '0; eb = '0; ed = '0;
    if (g >= 0) begin
      ew = wr[g[0]]; ea = ad[g[0]]; eb = be[g[0]]; ed = wd[g[0]];
    end
    chk("ack0", 32'(m0_ack), 32'(g == 0));
    chk("ack1", 32'(m1_ack), 32'(g == 1));
    chk("cs", 32'(mem_chipselect), 32'(g >= 0));
    chk("mwr", 32'(mem_write), 32'(ew));
    chk("maddr", 32'(mem_address), 32'(ea));
    chk("mbe", 32'(mem_byteenable), 32'(eb));
    chk("mwd", mem_writedata, ed);
    e0 = !reset && pend == 0;
    e1 = !reset && pend == 1;
    chk("rdv0", 32'(m0_readdatavalid), 32'(e0));
    chk("rdv1", 32'(m1_readdatavalid), 32'(e1));
    if (e0) chk("rdata0", m0_readdata, pend_d);
    if (e1) chk("rdata1", m1_readdata, pend_d);
  endtask

  task automatic tick();
    logic i;
    logic o;
    @(posedge clk);
    if (reset) begin
      own = -1; held = 0; last = 1; fpref = -1; pend = -1;
    end else begin
      pend = -1;
      if (g >= 0) begin
        i = g[0];
        last = g;
        if (!wr[i]) begin
          pend = g;
          pend_d = ref_mem[ad[i]];
        end else begin
          for (int b = 0; b < BW; b++)
            if (be[i][b]) ref_mem[ad[i]][8*b+:8] = wd[i][8*b+:8];
        end
      end
      if (own < 0) begin
        if (g >= 0) begin
          fpref = -1;
          if (lk[g[0]]) begin own = g; held = 1; end
        end
      end else begin
        o = own[0];
        held++;
        if (held >= LM) begin
          fpref = 1 - own; own = -1; held = 0;
        end else if ((g == own && !lk[o]) || (!rq[o] && !lk[o])) begin
          own = -1; held = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle_all();
    reset = 1'b0;
    for (int m = 0; m < 2; m++) begin
      logic mi;
      mi = m[0];
      rq[mi] = 1'b0; wr[mi] = 1'b0; lk[mi] = 1'b0;
      ad[mi] = '0; be[mi] = '0; wd[mi] = '0;
    end
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1'b1;
    settle();
    tick();
    reset = 1'b0;
  endtask

  int n0, n1, got1;

  initial begin
    for (int k = 0; k < 1024; k++) begin
      ref_mem[k] = '0;
      ram[k] <= '0;
    end
    ref_mem[5] = 32'hCAFE0001;
    ram[5] <= 32'hCAFE0001;
    idle_all();
    reset = 1'b1;
    settle();
    tick();
    do_reset();
    settle();
    tick();

    // single read by m1
    rq[1] = 1'b1; wr[1] = 1'b0; ad[1] = AW'(5);
    settle();
    chk("t1_ack", 32'(m1_ack), 32'd1);
    tick();
    idle_all();
    settle();
    chk("t1_rdv1", 32'(m1_readdatavalid), 32'd1);
    chk("t1_rdv0", 32'(m0_readdatavalid), 32'd0);
    chk("t1_data", m1_readdata, 32'hCAFE0001);
    tick();

    // round-robin after reset: m0, m1, m0, m1
    do_reset();
    rq[0] = 1'b1; ad[0] = AW'('h010);
    rq[1] = 1'b1; ad[1] = AW'('h020);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("rr_addr", 32'(mem_address), (i % 2 == 1) ? 32'h20 : 32'h10);
      tick();
    end
    idle_all();

    // locked 4-word burst by m0 while m1 waits
    do_reset();
    rq[1] = 1'b1; ad[1] = AW'('h030);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        rq[0] = 1'b1; wr[0] = 1'b1; ad[0] = AW'('h100 + i);
        be[0] = 4'hF; wd[0] = $urandom; lk[0] = (i < 3);
      end else begin
        rq[0] = 1'b0; lk[0] = 1'b0;
      end
      settle();
      if (i < 4) begin
        n0 += int'(m0_ack);
        n1 += int'(m1_ack);
      end else begin
        chk("lb_m1", 32'(m1_ack), 32'd1);
      end
      tick();
    end
    chk("lb_n0", n0, 32'd4);
    chk("lb_n1", n1, 32'd0);
    idle_all();

    // lock held forever by m0: forced release after LOCK_MAX grants
    do_reset();
    rq[0] = 1'b1; wr[0] = 1'b1; lk[0] = 1'b1; ad[0] = AW'('h200);
    be[0] = 4'hF; wd[0] = 32'h1234_5678;
    rq[1] = 1'b1; ad[1] = AW'('h201);
    n0 = 0; got1 = 0;
    for (int i = 0; i < 40 && got1 == 0; i++) begin
      settle();
      if (m1_ack) got1 = 1;
      else n0 += int'(m0_ack);
      tick();
    end
    chk("to_n0", n0, LM);
    chk("to_m1", got1, 32'd1);
    idle_all();
    settle();
    tick();

    // reset right after a locked read is issued
    rq[1] = 1'b1; wr[1] = 1'b0; ad[1] = AW'(5); lk[1] = 1'b1;
    settle();
    chk("rm_ack", 32'(m1_ack), 32'd1);
    tick();
    idle_all();
    reset = 1'b1;
    settle();
    chk("rm_rdv_a", 32'(m1_readdatavalid), 32'd0);
    tick();
    reset = 1'b0;
    rq[0] = 1'b1; wr[0] = 1'b0; ad[0] = AW'(7);
    settle();
    chk("rm_rdv_b", 32'(m1_readdatavalid), 32'd0);
    chk("rm_free", 32'(m0_ack), 32'd1);
    tick();
    idle_all();

    // byte-lane write then read back
    rq[0] = 1'b1; wr[0] = 1'b1; ad[0] = AW'('h3FF);
    be[0] = 4'b0101; wd[0] = 32'hAABBCCDD;
    settle();
    chk("bw_ack", 32'(m0_ack), 32'd1);
    tick();
    idle_all();
    rq[1] = 1'b1; wr[1] = 1'b0; ad[1] = AW'('h3FF);
    settle();
    tick();
    idle_all();
    settle();
    chk("bw_data", m1_readdata, 32'h00BB00DD);
    tick();

    // random traffic; fields held until acked
    g = -1;
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int m = 0; m < 2; m++) begin
        logic mi;
        mi = m[0];
        if (!(rq[mi] && g != m)) begin
          rq[mi] = ($urandom_range(0, 2) != 0);
          wr[mi] = 1'($urandom);
          ad[mi] = AW'($urandom_range(0, 15));
          be[mi] = BW'($urandom);
          wd[mi] = $urandom;
          lk[mi] = ($urandom_range(0, 3) == 0);
        end
      end
      settle();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_mem_port_arbiter.md
# spi_mem_port_arbiter

Two-requester arbiter that shares the SPI-side port (port B) of the 1024 x 32 SPI mailbox RAM between the SPI receive engine (master 0, writes incoming frames) and the SPI transmit engine (master 1, reads outgoing frames). It issues at most one RAM access per clock, resolves conflicts round-robin, and supports a bounded lock so a master can complete a multi-word frame without interleaving. It also routes the one-cycle-latency read data back to the issuing master.

## Interface
- ADDR_W, 10, word address width (1024 words)
- DATA_W, 32, data width; byteenable width is DATA_W/8
- LOCK_MAX, 16, maximum consecutive cycles a lock may be held before forced release
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- mN_req  in  1  master N (N = 0, 1) requests an access this cycle
- mN_write  in  1  1 = write, 0 = read
- mN_address  in  ADDR_W  word address
- mN_byteenable  in  DATA_W/8  byte lanes for writes
- mN_writedata  in  DATA_W  write data
- mN_lock  in  1  request or keep exclusive ownership after this access
- mN_ack  out  1  access accepted this cycle (combinational)
- mN_readdata  out  DATA_W  read data, qualified by mN_readdatavalid
- mN_readdatavalid  out  1  read data valid, registered
- mem_chipselect  out  1  to RAM port B chipselect
- mem_write  out  1  to RAM port B write
- mem_address  out  ADDR_W  to RAM port B address
- mem_byteenable  out  DATA_W/8  to RAM port B byteenable
- mem_writedata  out  DATA_W  to RAM port B writedata
- mem_readdata  in  DATA_W  from RAM port B readdata; valid one cycle after a read is issued

## Operation
- Grant is combinational from mN_req, owner state and last_grant register; grant implies mN_ack = 1 and the mem_* outputs mirror that master's signals with mem_chipselect = 1.
- No grant: mem_chipselect = 0, mem_write = 0, and mem_address/byteenable/writedata = 0.
- Owner FSM: states FREE, OWN0, OWN1.
  - FREE: one requester -> granted. Both -> master other than last_grant granted. Granted access with lock = 1 -> OWNn next cycle, lock counter = 1.
  - OWNn: only master n can be granted; the other master's req is held off (ack = 0).
  - OWNn -> FREE when: master n is granted with lock = 0; master n has req = 0 and lock = 0; or lock counter reaches LOCK_MAX (release happens at the end of that cycle, and that cycle's access by n is still granted).
  - Lock counter increments every cycle in OWNn and saturates at LOCK_MAX. It is cleared on entry to FREE.
- last_grant updates to the granted master on every grant.
- Forced release: the next grant goes to the other master if it is requesting, regardless of last_grant.
- Read return: a registered tag captures {valid, master} for a granted read. Next cycle, the tagged master's mN_readdatavalid = 1. Both mN_readdata are driven directly from mem_readdata.
- Writes produce no readdatavalid.

## Timing
- Reset values: last_grant = 1 (master 0 wins the first conflict), FSM = FREE, lock counter = 0, read tag invalid, all mN_readdatavalid = 0. All combinational outputs are 0 while no request is present.
- Access acceptance: 0-cycle, with ack in the same cycle as req.
- Read latency: exactly 1 cycle from ack to readdatavalid.
- Throughput: one access per cycle, with back-to-back reads fully pipelined.
- A master holds its request fields stable until acked.
- Reset asserted mid-operation clears an in-flight read tag, so no readdatavalid occurs in the following cycle, and drops any lock.
- Simultaneous requests while in FREE with lock on the winner: the loser waits until release.

## Test plan
- Single reads: m1 reads addr 0x005 holding 0xCAFE0001, with m0 idle -> m1_ack in the same cycle, m1_readdatavalid the next cycle with m1_readdata = 0xCAFE0001, and m0_readdatavalid = 0.
- Round-robin: both masters request every cycle for 4 cycles after reset -> grants m0, m1, m0, m1; mem_address alternates between the two addresses.
- Lock burst: m0 writes 0x100-0x103 with lock = 1 on the first 3 words and lock = 0 on the last, while m1 requests throughout -> 4 consecutive m0 acks with no m1 ack, then m1 acked on the 5th cycle.
- Lock timeout: m0 holds req = 1 and lock = 1 indefinitely while m1 requests -> exactly LOCK_MAX = 16 m0 acks, then m1 acked on the next cycle.
- Reset mid-read: m1 read acked, then reset asserted in the following cycle -> m1_readdatavalid = 0 in that cycle and the next, and FSM = FREE.
- Byte write: m0 writes 0xAABBCCDD with byteenable = 4'b0101 to 0x3FF, then m1 reads 0x3FF with the prior contents 0 -> readdata = 0x00BB00DD.
